nav_msg_gen: RTL and testbench

- Navigation-data source feeding msg_in of the GPS signal generator core; replaces the raw external message pin with a paced bit stream.
- Holds each data bit for EPOCHS_PER_BIT C/A-code epochs (20 → 50 bps), counted from the core's once-per-code-period start pulse.
- Data comes from a small byte FIFO loaded over a valid/ready port, or from one of four fixed presets.

---
 rtl/nav_msg_pkg.sv | 30 +++
 rtl/nav_byte_fifo.sv | 65 ++++++
 rtl/nav_msg_gen.sv | 132 +++++++++++++
 tb/tb_nav_msg_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_msg_pkg.sv
// Shared constants for the navigation message source: preset bytes and FSM encoding.
// No logic; pure definitions plus a combinational preset lookup.
// No flow control.
package nav_msg_pkg;

    // Fixed message bytes selectable instead of FIFO data
    localparam logic [7:0] PRESET_ZEROS    = 8'h00;
    localparam logic [7:0] PRESET_ONES     = 8'hFF;
    localparam logic [7:0] PRESET_ALT      = 8'hAA;
    localparam logic [7:0] PRESET_PREAMBLE = 8'h8B;

    // Bit pacer FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // 20 C/A epochs of 1 ms give the 50 bps navigation rate
    localparam int DEF_EPOCHS_PER_BIT = 20;

    function automatic logic [7:0] preset_byte(input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = PRESET_ZEROS;
            2'd1:    b = PRESET_ONES;
            2'd2:    b = PRESET_ALT;
            default: b = PRESET_PREAMBLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nav_byte_fifo.sv
// Small synchronous FIFO with level and full/empty flags.
// Latency: a pushed entry is visible at pop_dat the cycle after the push edge.
// Backpressure: pushes while full are dropped; pops while empty are ignored.
module nav_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst_in_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign pop_dat = mem[rd_ptr];
    // A pop on an empty FIFO never bypasses a same-cycle push
    assign do_push = push_vld & ~full;
    assign do_pop  = pop_rdy & ~empty;

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nav_msg_gen.sv
// Paces navigation bits onto the core msg input, one bit per EPOCHS_PER_BIT code epochs.
// Latency: msg_out/bit_strobe_out change on the edge that samples the boundary epoch_in.
// Backpressure: ld_ready_out drops when the byte FIFO is full; an empty FIFO at a byte fetch sends 0 and flags underflow.
module nav_msg_gen
    import nav_msg_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int EPOCHS_PER_BIT = DEF_EPOCHS_PER_BIT,
    parameter int EPOCH_CNT_W    = 5
) (
    input  logic       clk_in,
    input  logic       rst_in_n,
    input  logic       ena_in,
    input  logic       epoch_in,
    input  logic       use_msg_preset_in,
    input  logic [1:0] preset_sel_in,
    input  logic       ld_valid_in,
    input  logic [7:0] ld_data_in,
    output logic       ld_ready_out,
    input  logic       clr_underflow_in,
    output logic       msg_out,
    output logic       bit_strobe_out,
    output logic       underflow_out,
    output logic [2:0] fifo_level_out
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [0:0]             state;
    logic [EPOCH_CNT_W-1:0] epoch_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic                   msg_q;
    logic                   strobe_q;
    logic                   underflow_q;

    logic [7:0]             fifo_dat;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LW-1:0]          fifo_level;

    logic                   tick;
    logic                   epoch_wrap;
    logic                   boundary;
    logic                   fetch;
    logic                   fifo_pop;
    logic                   underflow_set;
    logic [7:0]             fetch_byte;
    logic                   cur_bit;

    // Only enabled epochs advance the pacer
    assign tick       = ena_in & epoch_in;
    assign epoch_wrap = (epoch_cnt == EPOCH_CNT_W'(EPOCHS_PER_BIT - 1));
    // First enabled epoch out of IDLE starts bit 0 immediately
    assign boundary   = tick & ((state == ST_IDLE) | epoch_wrap);
    assign fetch      = boundary & (bit_idx == 3'd7);
    // Preset mode leaves FIFO contents untouched for later use
    assign fifo_pop      = fetch & ~use_msg_preset_in & ~fifo_empty;
    assign underflow_set = fetch & ~use_msg_preset_in & fifo_empty;

    // Source select for the next byte; empty FIFO supplies zeros
    always_comb begin
        fetch_byte = 8'h00;
        if (use_msg_preset_in) begin
            fetch_byte = preset_byte(preset_sel_in);
        end else if (!fifo_empty) begin
            fetch_byte = fifo_dat;
        end
        cur_bit = fetch ? fetch_byte[7] : shreg[bit_idx];
    end

    nav_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8),
        .LW    (LW)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .push_vld (ld_valid_in),
        .push_dat (ld_data_in),
        .pop_rdy  (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // FSM, epoch counter, bit shifter and sticky underflow
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state       <= ST_IDLE;
            epoch_cnt   <= '0;
            bit_idx     <= 3'd7;
            shreg       <= 8'h00;
            msg_q       <= 1'b0;
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            strobe_q <= boundary;
            if (tick) begin
                if (state == ST_IDLE) begin
                    state <= ST_RUN;
                end else if (epoch_wrap) begin
                    epoch_cnt <= '0;
                end else begin
                    epoch_cnt <= epoch_cnt + EPOCH_CNT_W'(1);
                end
            end
            if (boundary) begin
                msg_q   <= cur_bit;
                bit_idx <= bit_idx - 3'd1;
                if (fetch) begin
                    shreg <= fetch_byte;
                end
            end
            // A new underflow wins over a same-cycle clear
            if (underflow_set) begin
                underflow_q <= 1'b1;
            end else if (clr_underflow_in) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // Not-full is the same as level < FIFO_DEPTH
    assign ld_ready_out   = ~fifo_full;
    assign fifo_level_out = 3'(fifo_level);
    assign msg_out        = msg_q;
    assign bit_strobe_out = strobe_q;
    assign underflow_out  = underflow_q;

endmodule

// File: tb/tb_nav_msg_gen.sv
// Directed bench for nav_msg_gen: preset table plus FIFO, underflow, overflow,
// enable-freeze, mid-byte preset change and mid-byte reset sequences.
// Inputs change 1 time unit after the rising edge; outputs are read at the same point.
module tb_nav_msg_gen;

    localparam int EPB = 20;

    logic       clk = 1'b0;
    logic       rst_in_n;
    logic       ena_in;
    logic       epoch_in;
    logic       use_msg_preset_in;
    logic [1:0] preset_sel_in;
    logic       ld_valid_in;
    logic [7:0] ld_data_in;
    logic       ld_ready_out;
    logic       clr_underflow_in;
    logic       msg_out;
    logic       bit_strobe_out;
    logic       underflow_out;
    logic [2:0] fifo_level_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] bits;
    int          nstrobe;
    int          bad_space;
    int          extra;
    int          prev_cyc;

    typedef struct {
        logic       use_p;
        logic [1:0] sel;
        int         gap;
        logic [7:0] exp_byte;
        logic       exp_uf;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nav_msg_gen #(
        .FIFO_DEPTH     (4),
        .EPOCHS_PER_BIT (EPB),
        .EPOCH_CNT_W    (5)
    ) dut (
        .clk_in            (clk),
        .rst_in_n          (rst_in_n),
        .ena_in            (ena_in),
        .epoch_in          (epoch_in),
        .use_msg_preset_in (use_msg_preset_in),
        .preset_sel_in     (preset_sel_in),
        .ld_valid_in       (ld_valid_in),
        .ld_data_in        (ld_data_in),
        .ld_ready_out      (ld_ready_out),
        .clr_underflow_in  (clr_underflow_in),
        .msg_out           (msg_out),
        .bit_strobe_out    (bit_strobe_out),
        .underflow_out     (underflow_out),
        .fifo_level_out    (fifo_level_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_in_n         = 1'b0;
        ena_in           = 1'b1;
        epoch_in         = 1'b0;
        ld_valid_in      = 1'b0;
        ld_data_in       = 8'h00;
        clr_underflow_in = 1'b0;
        step();
        step();
        rst_in_n = 1'b1;
    endtask

    task automatic clr_stats();
        bits      = '0;
        nstrobe   = 0;
        bad_space = 0;
        extra     = 0;
        prev_cyc  = -1;
    endtask

    task automatic push(input logic [7:0] d);
        ld_valid_in = 1'b1;
        ld_data_in  = d;
        step();
        ld_valid_in = 1'b0;
    endtask

    // Issue n enabled epochs, one every gap cycles, collecting strobed bits
    task automatic run_epochs(input int n, input int gap);
        for (int e = 0; e < n; e++) begin
            epoch_in = 1'b1;
            step();
            if (bit_strobe_out) begin
                bits = {bits[30:0], msg_out};
                nstrobe++;
                if (prev_cyc >= 0 && (cyc - prev_cyc) != EPB * gap) bad_space++;
                prev_cyc = cyc;
            end
            epoch_in = 1'b0;
            for (int g = 1; g < gap; g++) begin
                step();
                if (bit_strobe_out) extra++;
            end
        end
    endtask

    initial begin
        logic rdy_hist [5];
        int   frozen_bad;

        tbl[0] = '{1'b1, 2'd0, 2,  8'h00, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 2,  8'hFF, 1'b0};
        tbl[2] = '{1'b1, 2'd2, 2,  8'hAA, 1'b0};
        tbl[3] = '{1'b1, 2'd3, 16, 8'h8B, 1'b0};
        tbl[4] = '{1'b0, 2'd3, 2,  8'h00, 1'b1};

        use_msg_preset_in = 1'b1;
        preset_sel_in     = 2'd0;
        do_reset();
        chk("rst_msg", 32'(msg_out), 0);
        chk("rst_strobe", 32'(bit_strobe_out), 0);
        chk("rst_uf", 32'(underflow_out), 0);
        chk("rst_level", 32'(fifo_level_out), 0);
        chk("rst_ready", 32'(ld_ready_out), 1);

        // One full byte per source setting
        for (int i = 0; i < 5; i++) begin
            use_msg_preset_in = tbl[i].use_p;
            preset_sel_in     = tbl[i].sel;
            do_reset();
            clr_stats();
            run_epochs(8 * EPB, tbl[i].gap);
            chk($sformatf("tbl%0d_byte", i), 32'(bits[7:0]), 32'(tbl[i].exp_byte));
            chk($sformatf("tbl%0d_nstrobe", i), nstrobe, 8);
            chk($sformatf("tbl%0d_spacing", i), bad_space, 0);
            chk($sformatf("tbl%0d_extra", i), extra, 0);
            chk($sformatf("tbl%0d_uf", i), 32'(underflow_out), 32'(tbl[i].exp_uf));
        end

        // FIFO source, two bytes
        use_msg_preset_in = 1'b0;
        do_reset();
        push(8'hC3);
        push(8'h5A);
        chk("fifo_level2", 32'(fifo_level_out), 2);
        clr_stats();
        run_epochs(1, 2);
        chk("fifo_level1", 32'(fifo_level_out), 1);
        run_epochs(8 * EPB - 1, 2);
        chk("fifo_byte0", 32'(bits[7:0]), 32'hC3);
        run_epochs(1, 2);
        chk("fifo_level0", 32'(fifo_level_out), 0);
        run_epochs(8 * EPB - 1, 2);
        chk("fifo_bytes", 32'(bits[15:0]), 32'hC35A);
        chk("fifo_uf", 32'(underflow_out), 0);

        // Underflow set, hold, clear, and set-beats-clear
        do_reset();
        clr_stats();
        run_epochs(1, 2);
        chk("uf_bit", 32'(msg_out), 0);
        chk("uf_set", 32'(underflow_out), 1);
        repeat (3) step();
        chk("uf_hold", 32'(underflow_out), 1);
        clr_underflow_in = 1'b1;
        step();
        clr_underflow_in = 1'b0;
        chk("uf_clr", 32'(underflow_out), 0);
        run_epochs(8 * EPB - 1, 2);
        chk("uf_no_fetch", 32'(underflow_out), 0);
        epoch_in         = 1'b1;
        clr_underflow_in = 1'b1;
        step();
        epoch_in         = 1'b0;
        clr_underflow_in = 1'b0;
        chk("uf_fetch_strobe", 32'(bit_strobe_out), 1);
        chk("uf_set_wins", 32'(underflow_out), 1);

        // Overflow: five pushes into a four-deep FIFO
        do_reset();
        for (int k = 0; k < 5; k++) begin
            ld_valid_in = 1'b1;
            ld_data_in  = 8'(k + 1);
            step();
            rdy_hist[k] = ld_ready_out;
        end
        ld_valid_in = 1'b0;
        chk("ovf_rdy3", 32'(rdy_hist[2]), 1);
        chk("ovf_rdy4", 32'(rdy_hist[3]), 0);
        chk("ovf_level", 32'(fifo_level_out), 4);
        clr_stats();
        run_epochs(4 * 8 * EPB, 2);
        chk("ovf_data", bits, 32'h01020304);
        chk("ovf_uf_before", 32'(underflow_out), 0);
        run_epochs(1, 2);
        chk("ovf_fifth_dropped", 32'(underflow_out), 1);

        // Enable freeze mid-bit
        use_msg_preset_in = 1'b1;
        preset_sel_in     = 2'd2;
        do_reset();
        clr_stats();
        run_epochs(1, 2);
        chk("frz_first", 32'(msg_out), 1);
        run_epochs(10, 2);
        ena_in     = 1'b0;
        frozen_bad = 0;
        for (int c = 0; c < 100; c++) begin
            epoch_in = ((c % 2) == 0);
            step();
            if (bit_strobe_out || msg_out !== 1'b1) frozen_bad++;
        end
        epoch_in = 1'b0;
        ena_in   = 1'b1;
        chk("frz_hold", frozen_bad, 0);
        run_epochs(9, 2);
        chk("frz_no_early", nstrobe, 1);
        run_epochs(1, 2);
        chk("frz_resume_strobe", nstrobe, 2);
        chk("frz_resume_bit", 32'(msg_out), 0);

        // Preset change mid-byte, then reset mid-byte
        preset_sel_in = 2'd0;
        do_reset();
        clr_stats();
        run_epochs(3 * EPB, 2);
        preset_sel_in = 2'd1;
        run_epochs(5 * EPB, 2);
        run_epochs(8 * EPB, 2);
        chk("chg_bits", 32'(bits[15:0]), 32'h00FF);
        chk("chg_nstrobe", nstrobe, 16);
        push(8'h12);
        push(8'h34);
        run_epochs(3 * EPB + 7, 2);
        chk("pre_level_kept", 32'(fifo_level_out), 2);
        rst_in_n = 1'b0;
        step();
        chk("mid_rst_msg", 32'(msg_out), 0);
        chk("mid_rst_strobe", 32'(bit_strobe_out), 0);
        chk("mid_rst_level", 32'(fifo_level_out), 0);
        chk("mid_rst_ready", 32'(ld_ready_out), 1);
        chk("mid_rst_uf", 32'(underflow_out), 0);
        rst_in_n = 1'b1;
        clr_stats();
        run_epochs(1, 2);
        chk("post_rst_strobe", nstrobe, 1);
        chk("post_rst_bit", 32'(msg_out), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
